ysyx_23060042_idu_stage: RTL and testbench
==========================================

# ysyx_23060042_idu_stage

Registered RV32 decode stage between IFU and EXU. Accepts fetched instructions over a valid/ready handshake and decodes them into register indices, an immediate, and a micro-command bundle. Results are held in a two-entry buffer so that `in_ready` comes straight from a register. Compared with the combinational decoder, it adds configurable register-file size (RV32I/RV32E), optional M-extension decode, illegal-instruction detection and pipeline flush.

## Interface
- `NR_REG`, default 32: architectural register count, either 32 (RV32I) or 16 (RV32E).
- `HAS_M`, default 0: when 1, decode MUL/DIV/REM (opcode 0110011, funct7 0000001).
- `PC_W`, default 32: width of the PC carried alongside each instruction.
- `clk` input, 1: clock. All state changes on its rising edge.
- `rst` input, 1: synchronous, active-high reset.
- `flush` input, 1: drop every buffered and incoming instruction.
- `in_valid` input, 1: IFU offers an instruction.
- `in_ready` output, 1: stage can accept an instruction. Registered.
- `in_inst` input, 32: instruction word.
- `in_pc` input, PC_W: PC of the instruction.
- `out_valid` output, 1: decoded bundle valid.
- `out_ready` input, 1: EXU accepts the bundle.
- `out_pc` output, PC_W: PC of the decoded instruction.
- `opcode`, 7; `func3`, 3; `rs1`, `rs2`, `rd`, 5 each: instruction fields.
- `imm` output, 32: sign-extended immediate for the selected immediate type.
- `regen`, `pcjen`, `pcren` outputs, 1 each: register-write, PC-jump and PC-read enables.
- `mwen`, `mren` outputs, 2 each: memory write/read size code (00 none, 01 byte, 10 half, 11 word).
- `aluop` output, 4: ALU operation, encoded per the package.
- `jalen` output, 1: equals `regen & pcjen`.
- `brken` output, 1: instruction is ebreak, 0x00100073.
- `illegal` output, 1: instruction is undecodable.

## Operation
- **Decode.** Decode is combinational on `in_inst`. The full bundle is captured into a buffer entry at accept time (`in_valid & in_ready`).
- **Immediate types.** R gives 0. I, S, B, U and J follow the RV32 formats with sign bit `inst[31]`. B and J immediates have bit 0 equal to 0.
- **Illegal.** `illegal` is 1 when:
  - the opcode, funct3 or funct7 combination is not in the table; or
  - `HAS_M`=0 and the instruction is an M-extension op; or
  - `NR_REG`=16 and bit 4 of any used `rs1`, `rs2` or `rd` is 1.
- **Illegal outputs.** When `illegal`=1, `regen`, `pcjen`, `mwen`, `mren` and `brken` are forced to 0, and `aluop` is forced to ADD.
- **brken.** `brken` is asserted only for the exact ebreak encoding. The older "no side effects" heuristic is not used.
- **Buffer.** The buffer has two entries, HEAD and SKID, with occupancy states EMPTY, ONE and FULL:
  - EMPTY, accept: go to ONE.
  - ONE, accept without pop: go to FULL.
  - ONE, pop without accept: go to EMPTY.
  - ONE, accept and pop together: stay in ONE, with HEAD replaced by the new entry.
  - FULL, pop: SKID moves to HEAD, go to ONE. No accept is possible in FULL.
- **Ready and valid.** `in_ready` is registered and equals `state != FULL` for the next cycle. `out_valid` equals `state != EMPTY`, and all outputs are driven from HEAD.
- **Flush.** `flush`=1 sends the next state to EMPTY. Any concurrent accept is discarded. Flush takes priority over accept and pop.
- **Reset.** `rst` forces state EMPTY. Reset takes priority over `flush`.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N is on the outputs with `out_valid`=1 after edge N.
- Throughput is 1 instruction per cycle while `out_ready`=1.
- After `out_ready` deasserts, `in_ready` falls one cycle later. The SKID entry absorbs the one accept made during that cycle.
- `out_valid`, once high, holds and the bundle stays stable until a pop or flush.
- Reset values:
  - `in_ready`=1, `out_valid`=0.
  - All bundle outputs 0; `aluop` is ADD (0) and `illegal`=0.
  - `out_pc`=0.
- During reset or flush no data is lost apart from what is deliberately dropped. The cycle after either, `in_ready`=1.

## Structure
- Package `ysyx_23060042_idu_pkg`:
  - opcode constants;
  - `imm_type_e` (R, I, S, B, U, J);
  - `aluop_e`, 4-bit: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, MUL, MULH, DIV, DIVU, REM, REMU;
  - packed struct `dec_bundle_t` holding every decoded output plus `pc`.
- Sub-module `ysyx_23060042_idu_dec`: purely combinational, `inst` to `dec_bundle_t`, parameterised by `NR_REG` and `HAS_M`.
- The stage itself instantiates the decoder and holds two `dec_bundle_t` registers plus the state register.

## Test plan
- **Basic decode.** `rst` for 2 cycles, then `addi x1,x0,5` (0x00500093) at pc 0x80000000 with `out_ready`=1. One cycle later: `out_valid`=1, `rd`=1, `rs1`=0, `imm`=5, `regen`=1, `aluop`=ADD, `out_pc`=0x80000000.
- **Immediates.** `jal x1,-4` (0xFFDFF0EF) gives `imm`=0xFFFFFFFC and `jalen`=1. `sw x2,-8(x1)` (0xFE20AC23) gives `imm`=0xFFFFFFF8, `mwen`=11 and `regen`=0.
- **Backpressure.** Stream 4 instructions with `out_ready`=0. Expect 2 accepted, `in_ready` low from the cycle after the second accept, and HEAD stable. Release `out_ready`: all 4 emerge in order with no duplicates.
- **M-extension gating.** `mul x3,x1,x2` (0x022081B3): with `HAS_M`=0, `illegal`=1 and `regen`=0; with `HAS_M`=1, `aluop`=MUL and `illegal`=0. With `NR_REG`=16, `addi x17,x0,1` (0x00100893) gives `illegal`=1.
- **Flush and ebreak.** Assert `flush` in FULL while `in_valid`=1. Next cycle `out_valid`=0 and `in_ready`=1, and the flushed instructions never appear. Then ebreak (0x00100073) gives `brken`=1; `ecall` (0x00000073) gives `brken`=0.
- **Mid-stream reset.** `rst` during a simultaneous accept and pop gives EMPTY and all outputs at their reset values on the next cycle.

Source files
------------

// File: rtl/ysyx_23060042_idu_pkg.sv
// Shared types for the RV32 decode stage: opcodes, immediate formats, ALU
// operations and the decoded bundle carried through the two-entry buffer.
package ysyx_23060042_idu_pkg;

    // Widest PC the bundle can carry; the stage zero-extends and truncates to PC_W.
    localparam int PC_STORE_W = 64;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

    typedef enum logic [2:0] {IMM_R, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_e;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
        ALU_OR, ALU_AND, ALU_MUL, ALU_MULH, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
    } aluop_e;

    typedef struct packed {
        logic [PC_STORE_W-1:0] pc;
        logic [6:0]            opcode;
        logic [2:0]            func3;
        logic [4:0]            rs1;
        logic [4:0]            rs2;
        logic [4:0]            rd;
        logic [31:0]           imm;
        logic                  regen;
        logic                  pcjen;
        logic                  pcren;
        logic [1:0]            mwen;
        logic [1:0]            mren;
        aluop_e                aluop;
        logic                  jalen;
        logic                  brken;
        logic                  illegal;
    } dec_bundle_t;

    // alt selects SUB/SRA (funct7 bit 5) for the funct3 codes that have them.
    function automatic aluop_e alu_base(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_23060042_idu_dec.sv
// Combinational RV32I/E (+ optional M) decoder producing the full bundle
// except the PC, with illegal-instruction detection and side-effect masking.
module ysyx_23060042_idu_dec
    import ysyx_23060042_idu_pkg::*;
#(
    parameter int NR_REG = 32,
    parameter bit HAS_M  = 1'b0
) (
    input  logic [31:0] inst,
    output dec_bundle_t dec
);
    logic [6:0] op;
    logic [6:0] f7;
    logic [2:0] f3;
    imm_type_e  itype;
    logic       legal;
    logic       use_rs1;
    logic       use_rs2;
    logic       use_rd;
    logic       reg_hi;

    assign op = inst[6:0];
    assign f3 = inst[14:12];
    assign f7 = inst[31:25];

    always_comb begin
        dec        = '0;
        dec.opcode = op;
        dec.func3  = f3;
        dec.rs1    = inst[19:15];
        dec.rs2    = inst[24:20];
        dec.rd     = inst[11:7];
        itype      = IMM_R;
        legal      = 1'b0;

        case (op)
            OPC_LUI:    begin itype = IMM_U; legal = 1'b1; dec.regen = 1'b1; end
            OPC_AUIPC:  begin itype = IMM_U; legal = 1'b1; dec.regen = 1'b1; dec.pcren = 1'b1; end
            OPC_JAL: begin
                itype = IMM_J; legal = 1'b1;
                dec.regen = 1'b1; dec.pcjen = 1'b1; dec.pcren = 1'b1;
            end
            OPC_JALR: begin
                itype = IMM_I; legal = (f3 == 3'b000);
                dec.regen = 1'b1; dec.pcjen = 1'b1;
            end
            OPC_BRANCH: begin
                itype = IMM_B; legal = (f3[2:1] != 2'b01);
                dec.pcjen = 1'b1; dec.pcren = 1'b1;
                dec.aluop = f3[2] ? (f3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
            end
            OPC_LOAD: begin
                itype = IMM_I; legal = (f3[1:0] != 2'b11) && (f3 != 3'b110);
                dec.regen = 1'b1; dec.mren = f3[1:0] + 2'd1;
            end
            OPC_STORE: begin
                itype = IMM_S; legal = !f3[2] && (f3[1:0] != 2'b11);
                dec.mwen = f3[1:0] + 2'd1;
            end
            OPC_OP_IMM: begin
                itype = IMM_I; dec.regen = 1'b1;
                if (f3 == 3'b001)      legal = (f7 == 7'b0000000);
                else if (f3 == 3'b101) legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
                else                   legal = 1'b1;
                dec.aluop = alu_base(f3, (f3 == 3'b101) && f7[5]);
            end
            OPC_OP: begin
                itype = IMM_R; dec.regen = 1'b1;
                if (f7 == 7'b0000001) begin
                    legal = HAS_M;
                    case (f3)
                        3'b000:  dec.aluop = ALU_MUL;
                        3'b100:  dec.aluop = ALU_DIV;
                        3'b101:  dec.aluop = ALU_DIVU;
                        3'b110:  dec.aluop = ALU_REM;
                        3'b111:  dec.aluop = ALU_REMU;
                        default: dec.aluop = ALU_MULH;  // MULH/MULHSU/MULHU, told apart by func3
                    endcase
                end else begin
                    legal = (f7 == 7'b0000000) ||
                            ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
                    dec.aluop = alu_base(f3, f7[5]);
                end
            end
            OPC_SYSTEM: begin
                itype = IMM_I;
                legal = (inst == INST_ECALL) || (inst == INST_EBREAK);
                dec.brken = (inst == INST_EBREAK);
            end
            default: legal = 1'b0;
        endcase

        // RV32E: only x0..x15 exist, so bit 4 of any field the format reads must be 0.
        use_rs1 = (itype == IMM_R) || (itype == IMM_I) || (itype == IMM_S) || (itype == IMM_B);
        use_rs2 = (itype == IMM_R) || (itype == IMM_S) || (itype == IMM_B);
        use_rd  = (itype == IMM_R) || (itype == IMM_I) || (itype == IMM_U) || (itype == IMM_J);
        reg_hi  = (use_rs1 && inst[19]) || (use_rs2 && inst[24]) || (use_rd && inst[11]);
        if ((NR_REG == 16) && reg_hi) legal = 1'b0;

        case (itype)
            IMM_I:   dec.imm = {{20{inst[31]}}, inst[31:20]};
            IMM_S:   dec.imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:   dec.imm = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U:   dec.imm = {inst[31:12], 12'b0};
            IMM_J:   dec.imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
            default: dec.imm = '0;
        endcase

        if (!legal) begin
            dec.regen = 1'b0;
            dec.pcjen = 1'b0;
            dec.mwen  = 2'b00;
            dec.mren  = 2'b00;
            dec.brken = 1'b0;
            dec.aluop = ALU_ADD;
        end
        dec.illegal = !legal;
        dec.jalen   = dec.regen & dec.pcjen;
    end

endmodule

// File: rtl/ysyx_23060042_idu_stage.sv
// Registered decode stage: decoder in front of a HEAD/SKID buffer so that
// in_ready is a flop and one extra accept is absorbed when out_ready drops.
module ysyx_23060042_idu_stage
    import ysyx_23060042_idu_pkg::*;
#(
    parameter int NR_REG = 32,
    parameter bit HAS_M  = 1'b0,
    parameter int PC_W   = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [6:0]      opcode,
    output logic [2:0]      func3,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [31:0]     imm,
    output logic            regen,
    output logic            pcjen,
    output logic            pcren,
    output logic [1:0]      mwen,
    output logic [1:0]      mren,
    output logic [3:0]      aluop,
    output logic            jalen,
    output logic            brken,
    output logic            illegal
);
    typedef enum logic [1:0] {BUF_EMPTY, BUF_ONE, BUF_FULL} buf_state_e;

    buf_state_e  state;
    buf_state_e  state_next;
    dec_bundle_t dec;
    dec_bundle_t incoming;
    dec_bundle_t head;
    dec_bundle_t skid;
    logic        ready_q;
    logic        accept;
    logic        pop;

    ysyx_23060042_idu_dec #(.NR_REG(NR_REG), .HAS_M(HAS_M)) u_dec (
        .inst (in_inst),
        .dec  (dec)
    );

    always_comb begin
        incoming    = dec;
        incoming.pc = PC_STORE_W'(in_pc);
    end

    assign accept = in_valid & ready_q;
    assign pop    = (state != BUF_EMPTY) & out_ready;

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = BUF_EMPTY;
        end else begin
            case (state)
                BUF_EMPTY: if (accept) state_next = BUF_ONE;
                BUF_ONE: begin
                    if (accept && !pop)      state_next = BUF_FULL;
                    else if (!accept && pop) state_next = BUF_EMPTY;
                end
                BUF_FULL:  if (pop) state_next = BUF_ONE;
                default:   state_next = BUF_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= BUF_EMPTY;
            ready_q <= 1'b1;
        end else begin
            state   <= state_next;
            ready_q <= (state_next != BUF_FULL);
        end
    end

    // HEAD is cleared on reset because every output is driven straight from it.
    always_ff @(posedge clk) begin
        if (rst) begin
            head <= '0;
        end else if (!flush) begin
            case (state)
                BUF_EMPTY: if (accept) head <= incoming;
                BUF_ONE:   if (accept && pop) head <= incoming;
                BUF_FULL:  if (pop) head <= skid;
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if ((state == BUF_ONE) && accept && !pop) skid <= incoming;
    end

    assign in_ready  = ready_q;
    assign out_valid = (state != BUF_EMPTY);
    assign out_pc    = head.pc[PC_W-1:0];
    assign opcode    = head.opcode;
    assign func3     = head.func3;
    assign rs1       = head.rs1;
    assign rs2       = head.rs2;
    assign rd        = head.rd;
    assign imm       = head.imm;
    assign regen     = head.regen;
    assign pcjen     = head.pcjen;
    assign pcren     = head.pcren;
    assign mwen      = head.mwen;
    assign mren      = head.mren;
    assign aluop     = head.aluop;
    assign jalen     = head.jalen;
    assign brken     = head.brken;
    assign illegal   = head.illegal;

endmodule

// File: tb/tb_ysyx_23060042_idu_stage.sv
// Bench for the decode stage: three instances (RV32I, RV32I+M, RV32E) share
// one stimulus stream and are checked against a queue-based reference model.
module tb_ysyx_23060042_idu_stage;
    localparam int NI = 3;
    localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_SLT = 4'd3, A_SLTU = 4'd4, A_SRA = 4'd7;
    localparam logic [3:0] ALU_TAB [8] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    localparam logic [3:0] M_TAB   [8] = '{4'd10, 4'd11, 4'd11, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};
    localparam logic [31:0] ECALL = 32'h0000_0073, EBREAK = 32'h0010_0073;

    logic clk = 1'b0;
    logic rst, flush, in_valid, out_ready;
    logic [31:0] in_inst, in_pc;
    logic        in_ready [NI], out_valid [NI], regen [NI], pcjen [NI], pcren [NI];
    logic        jalen [NI], brken [NI], illegal [NI];
    logic [31:0] out_pc [NI], imm [NI];
    logic [6:0]  opcode [NI];
    logic [2:0]  func3 [NI];
    logic [4:0]  rs1 [NI], rs2 [NI], rd [NI];
    logic [1:0]  mwen [NI], mren [NI];
    logic [3:0]  aluop [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        ysyx_23060042_idu_stage #(.NR_REG((g == 2) ? 16 : 32), .HAS_M(g == 1), .PC_W(32)) dut (
            .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready[g]),
            .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid[g]), .out_ready(out_ready),
            .out_pc(out_pc[g]), .opcode(opcode[g]), .func3(func3[g]), .rs1(rs1[g]), .rs2(rs2[g]),
            .rd(rd[g]), .imm(imm[g]), .regen(regen[g]), .pcjen(pcjen[g]), .pcren(pcren[g]),
            .mwen(mwen[g]), .mren(mren[g]), .aluop(aluop[g]), .jalen(jalen[g]),
            .brken(brken[g]), .illegal(illegal[g])
        );
    end

    typedef struct {
        logic [31:0] pc, imm;
        logic [6:0]  opcode;
        logic [2:0]  func3;
        logic [4:0]  rs1, rs2, rd;
        logic        regen, pcjen, pcren, jalen, brken, illegal;
        logic [1:0]  mwen, mren;
        logic [3:0]  aluop;
    } exp_t;
    typedef struct { logic [31:0] inst, pc; } txn_t;

    txn_t        mq [$];
    logic [31:0] seen [$];
    int          n_asrt = 0, n_fail = 0;
    bit          last_acc;

    // Instruction semantics straight from the ISA tables.
    function automatic exp_t ref_dec(logic [31:0] w, logic [31:0] pc, bit has_m, bit rv32e);
        exp_t e;
        int   f3, f7;
        byte  fmt;
        bit   ok;
        e = '{default: '0};
        e.pc = pc; e.opcode = w[6:0]; e.func3 = w[14:12];
        e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.rd = w[11:7];
        f3 = int'(w[14:12]); f7 = int'(w[31:25]);
        fmt = "R"; ok = 0;
        case (w[6:0])
            7'h37: begin fmt = "U"; ok = 1; e.regen = 1; end
            7'h17: begin fmt = "U"; ok = 1; e.regen = 1; e.pcren = 1; end
            7'h6f: begin fmt = "J"; ok = 1; e.regen = 1; e.pcjen = 1; e.pcren = 1; end
            7'h67: begin fmt = "I"; ok = (f3 == 0); e.regen = 1; e.pcjen = 1; end
            7'h63: begin
                fmt = "B"; ok = (f3 != 2 && f3 != 3); e.pcjen = 1; e.pcren = 1;
                e.aluop = (f3 < 2) ? A_SUB : ((f3 < 6) ? A_SLT : A_SLTU);
            end
            7'h03: begin fmt = "I"; ok = (f3 inside {0, 1, 2, 4, 5}); e.regen = 1; e.mren = 2'(f3 % 4 + 1); end
            7'h23: begin fmt = "S"; ok = (f3 < 3); e.mwen = 2'(f3 + 1); end
            7'h13: begin
                fmt = "I"; e.regen = 1; e.aluop = ALU_TAB[f3];
                if (f3 == 1) ok = (f7 == 0);
                else if (f3 == 5) begin ok = (f7 == 0 || f7 == 32); if (f7 == 32) e.aluop = A_SRA; end
                else ok = 1;
            end
            7'h33: begin
                fmt = "R"; e.regen = 1;
                if (f7 == 1) begin ok = has_m; e.aluop = M_TAB[f3]; end
                else if (f7 == 0) begin ok = 1; e.aluop = ALU_TAB[f3]; end
                else if (f7 == 32) begin ok = (f3 == 0 || f3 == 5); e.aluop = (f3 == 0) ? A_SUB : A_SRA; end
            end
            7'h73: begin fmt = "I"; ok = (w == ECALL || w == EBREAK); e.brken = (w == EBREAK); end
            default: ;
        endcase
        case (fmt)
            "I": e.imm = int'($signed(w[31:20]));
            "S": e.imm = int'($signed({w[31:25], w[11:7]}));
            "B": e.imm = int'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
            "U": e.imm = w & 32'hFFFF_F000;
            "J": e.imm = int'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
            default: e.imm = 0;
        endcase
        if (rv32e) begin
            if ((fmt inside {"R", "I", "S", "B"}) && w[19]) ok = 0;
            if ((fmt inside {"R", "S", "B"}) && w[24]) ok = 0;
            if ((fmt inside {"R", "I", "U", "J"}) && w[11]) ok = 0;
        end
        if (!ok) begin
            e.regen = 0; e.pcjen = 0; e.mwen = 0; e.mren = 0; e.brken = 0; e.aluop = A_ADD;
        end
        e.illegal = !ok;
        e.jalen = e.regen & e.pcjen;
        return e;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [6:0]  ops [9];
        logic [31:0] w;
        ops = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
        w = $urandom;
        case ($urandom_range(0, 9))
            0: ;
            1: w = $urandom_range(0, 1) ? EBREAK : ECALL;
            2: begin w[6:0] = 7'h33; w[31:25] = ($urandom_range(0, 2) == 0) ? 7'h20 : 7'(($urandom_range(0, 1))); end
            3: begin w[6:0] = 7'h13; w[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00; end
            default: w[6:0] = ops[$urandom_range(0, 8)];
        endcase
        return w;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        exp_t e;
        for (int g = 0; g < NI; g++) begin
            chk($sformatf("%s.in_ready%0d", tag, g), in_ready[g], mq.size() < 2);
            chk($sformatf("%s.out_valid%0d", tag, g), out_valid[g], mq.size() != 0);
            if (mq.size() != 0) begin
                e = ref_dec(mq[0].inst, mq[0].pc, g == 1, g == 2);
                chk($sformatf("%s.pc%0d", tag, g), out_pc[g], e.pc);
                chk($sformatf("%s.opcode%0d", tag, g), opcode[g], e.opcode);
                chk($sformatf("%s.func3%0d", tag, g), func3[g], e.func3);
                chk($sformatf("%s.rs1_%0d", tag, g), rs1[g], e.rs1);
                chk($sformatf("%s.rs2_%0d", tag, g), rs2[g], e.rs2);
                chk($sformatf("%s.rd%0d", tag, g), rd[g], e.rd);
                chk($sformatf("%s.imm%0d", tag, g), imm[g], e.imm);
                chk($sformatf("%s.regen%0d", tag, g), regen[g], e.regen);
                chk($sformatf("%s.pcjen%0d", tag, g), pcjen[g], e.pcjen);
                chk($sformatf("%s.pcren%0d", tag, g), pcren[g], e.pcren);
                chk($sformatf("%s.mwen%0d", tag, g), mwen[g], e.mwen);
                chk($sformatf("%s.mren%0d", tag, g), mren[g], e.mren);
                chk($sformatf("%s.aluop%0d", tag, g), aluop[g], e.aluop);
                chk($sformatf("%s.jalen%0d", tag, g), jalen[g], e.jalen);
                chk($sformatf("%s.brken%0d", tag, g), brken[g], e.brken);
                chk($sformatf("%s.illegal%0d", tag, g), illegal[g], e.illegal);
            end
        end
    endtask

    task automatic chk_zero(input string tag);
        for (int g = 0; g < NI; g++) begin
            chk($sformatf("%s.bundle%0d", tag, g),
                {out_pc[g] | imm[g], 7'(opcode[g]), func3[g], rs1[g], rs2[g], rd[g], regen[g], pcjen[g],
                 pcren[g], mwen[g], mren[g], aluop[g], jalen[g], brken[g], illegal[g]} != 0, 0);
        end
    endtask

    // One clock: advance the queue model with the pre-edge inputs, then check.
    task automatic step(input string tag);
        bit pop;
        last_acc = in_valid && (mq.size() < 2);
        pop = (mq.size() > 0) && out_ready;
        if (!rst && !flush && out_valid[0] && out_ready) seen.push_back(out_pc[0]);
        @(posedge clk);
        if (rst || flush) mq.delete();
        else begin
            if (pop) void'(mq.pop_front());
            if (last_acc) mq.push_back('{inst: in_inst, pc: in_pc});
        end
        #1;
        check_all(tag);
    endtask

    task automatic drive(input logic [31:0] w, input logic [31:0] pc);
        in_valid = 1'b1; in_inst = w; in_pc = pc;
    endtask

    initial begin
        logic [31:0] prog [4];
        int idx;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_inst = '0; in_pc = '0;
        step("rst"); step("rst");
        chk_zero("rst_vals");
        rst = 1'b0;

        drive(32'h0050_0093, 32'h8000_0000); step("addi");
        chk("addi.out_valid", out_valid[0], 1); chk("addi.rd", rd[0], 1); chk("addi.rs1", rs1[0], 0);
        chk("addi.imm", imm[0], 5); chk("addi.regen", regen[0], 1); chk("addi.aluop", aluop[0], 0);
        chk("addi.pc", out_pc[0], 32'h8000_0000);
        drive(32'hFFDF_F0EF, 32'h8000_0004); step("jal");
        chk("jal.imm", imm[0], 32'hFFFF_FFFC); chk("jal.jalen", jalen[0], 1);
        drive(32'hFE20_AC23, 32'h8000_0008); step("sw");
        chk("sw.imm", imm[0], 32'hFFFF_FFF8); chk("sw.mwen", mwen[0], 3); chk("sw.regen", regen[0], 0);
        drive(32'h0220_81B3, 32'h8000_000C); step("mul");
        chk("mul.illegal_noM", illegal[0], 1); chk("mul.regen_noM", regen[0], 0);
        chk("mul.aluop_M", aluop[1], 10); chk("mul.illegal_M", illegal[1], 0);
        drive(32'h0010_0893, 32'h8000_0010); step("x17");
        chk("x17.illegal_E", illegal[2], 1); chk("x17.illegal_I", illegal[0], 0);
        in_valid = 1'b0; step("drain");

        prog = '{32'h0050_0093, 32'h00A0_0113, 32'h00F0_0193, 32'h0140_0213};
        idx = 0; out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            drive(prog[idx], 32'h100 + 32'(4 * idx)); step("bp_hold");
            if (last_acc) idx++;
        end
        chk("bp.accepted", idx, 2); chk("bp.in_ready", in_ready[0], 0);
        chk("bp.head_pc", out_pc[0], 32'h100);
        out_ready = 1'b1; seen.delete();
        for (int c = 0; c < 20 && seen.size() < 4; c++) begin
            in_valid = (idx < 4); in_inst = prog[(idx < 4) ? idx : 0]; in_pc = 32'h100 + 32'(4 * idx);
            step("bp_release");
            if (last_acc) idx++;
        end
        chk("bp.emerged", seen.size(), 4);
        for (int k = 0; k < seen.size() && k < 4; k++) chk($sformatf("bp.order%0d", k), seen[k], 32'h100 + 32'(4 * k));

        out_ready = 1'b0;
        drive(32'h0000_0013, 32'h200); step("fl_fill");
        drive(32'h0000_0013, 32'h204); step("fl_fill");
        drive(32'h0000_0013, 32'h208); flush = 1'b1; step("flush");
        chk("flush.out_valid", out_valid[0], 0); chk("flush.in_ready", in_ready[0], 1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; seen.delete();
        for (int c = 0; c < 3; c++) step("fl_after");
        chk("flush.none_seen", seen.size(), 0);

        drive(EBREAK, 32'h300); step("ebreak"); chk("ebreak.brken", brken[0], 1);
        drive(ECALL, 32'h304); step("ecall"); chk("ecall.brken", brken[0], 0); chk("ecall.illegal", illegal[0], 0);
        drive(32'h0050_0093, 32'h308); rst = 1'b1; step("midrst");
        chk_zero("midrst_vals"); chk("midrst.out_valid", out_valid[0], 0); chk("midrst.in_ready", in_ready[0], 1);
        rst = 1'b0;

        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 29) == 0);
            rst       = ($urandom_range(0, 99) == 0);
            in_inst   = rand_inst();
            in_pc     = $urandom & 32'hFFFF_FFFC;
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
